fisc_mem_responder: RTL and testbench
=====================================

// Module: fisc_mem_responder
// PURPOSE
//  Memory-side responder for the core's two memory channels (a, b). Serves read/write
//  strobes from one single-port DATA_W x 2**ADDR_W array, round-robin arbitrated.
//  Returns read data with a one-cycle ack pulse and drives wait_n to stall the core under contention.
// PARAMETERS
//  DATA_W  64  word width; equals FISC_INTEGER_SZ
//  ADDR_W  10  word-address width; array depth = 2**ADDR_W, so no address is out of range
// PORTS
//  clk      in   1       clock, rising edge
//  reset_n  in   1       synchronous, active-low reset
//  rd_a     in   1       channel a read strobe, active high
//  wr_a     in   1       channel a write strobe, active high
//  addr_a   in   ADDR_W  channel a word address
//  wdata_a  in   DATA_W  channel a write data (core dout_bus_a)
//  rdata_a  out  DATA_W  channel a read data (core din_bus_a)
//  ack_a    out  1       channel a access complete, one-cycle pulse
//  rd_b, wr_b, addr_b, wdata_b, rdata_b, ack_b: same as channel a
//  wait_n   out  1       0 = a captured request is waiting behind the other channel
// BEHAVIOUR
//  Reset: reset_n=0 at an edge -> state IDLE, pend_a=pend_b=0, ack_a=ack_b=0,
//   rdata_a=rdata_b=0, wait_n=1, rr_last=B (A wins the first tie). Array contents are untouched.
//  Capture: at an edge with (rd_x|wr_x)=1, pend_x=0 and ack_x=0 -> pend_x=1 and latch addr,
//   wdata and op. If wr_x=1, op=write; if only rd_x=1, op=read (wr wins when both strobes are high).
//  Requester holds the strobe until it sees ack_x, then drops it.
//   A strobe still high at the first edge after the ack cycle is a new request.
//  FSM IDLE -> SERVE -> ACK -> IDLE; serves one access per 3 cycles.
//   IDLE: if pend_a|pend_b, choose sel; go SERVE. Single pending channel: choose that channel.
//    Both pending: choose the channel != rr_last. Otherwise stay IDLE.
//   SERVE: perform the array op for sel. Write stores latched wdata. Read loads rdata_sel.
//    Clear pend_sel; rr_last=sel; go ACK.
//   ACK: ack_sel=1 for exactly this cycle; go IDLE. ack_sel returns to 0 at the next edge.
//  Latency: strobe sampled at edge E0 -> IDLE grants at E1 -> array op at E2 -> ack_x high
//   E2..E3. An uncontended access is acked 2 cycles after capture.
//  rdata_x holds its last read value until the next read on that channel completes.
//   A write does not change rdata_x.
//  A write followed by a read of the same address returns the new data.
//   The accesses are serialised, so there is no bypass path.
//  wait_n (registered) = 0 while, for some x, pend_x=1 and the FSM is serving the other channel.
//   Otherwise wait_n = 1.
//  Simultaneous capture on a and b: both pending; the loser waits one full service
//   (3 cycles); its ack follows 3 cycles after the winner's.
//  Capture during SERVE/ACK on the other channel is allowed; it is served on the next IDLE.
//  reset_n=0 during SERVE: reset wins; no array write occurs. Pending and ack are cleared.
//  ack_x and ack_y are never high in the same cycle.
//  Max address (2**ADDR_W-1) is a normal location; no wrap logic.
// TESTING
//  1. wr_a=1, addr_a=5, wdata_a=64'hDEAD_BEEF_0123_4567, then rd_a at addr 5
//     -> each ack_a 2 cycles after capture; rdata_a=64'hDEAD_BEEF_0123_4567.
//  2. rd_a@3 and rd_b@7 sampled at the same edge, array pre-written with 3->11, 7->22
//     -> ack_a first (rdata_a=11); wait_n=0 during A's service;
//     ack_b 3 cycles later (rdata_b=22); wait_n=1 afterwards.
//  3. Repeat simultaneous requests twice -> second round serves B first (round-robin).
//  4. rd_a held high across 3 accesses, addr changing after each ack
//     -> one ack per 4-cycle request window, no duplicate capture in ack cycle.
//  5. rd_b=wr_b=1 at addr 1023, wdata=64'h1 -> treated as write; later read of addr 1023 returns 1;
//     rdata_b unchanged by that write.
//  6. Write to addr 9 (old 64'hAA), reset_n=0 in SERVE cycle -> no ack, all outputs at reset values;
//     read of addr 9 returns 64'hAA.

Source files
------------

// File: rtl/fisc_mem_if.sv
// Core <-> memory-responder bus for channels a and b; strobes are held by the core until ack.
// wait_n tells the core that a captured request is queued behind the other channel.
interface fisc_mem_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
);
  logic              rd_a;
  logic              wr_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] rdata_a;
  logic              ack_a;
  logic              rd_b;
  logic              wr_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata_b;
  logic              ack_b;
  logic              wait_n;

  modport master (
    output rd_a, wr_a, addr_a, wdata_a, rd_b, wr_b, addr_b, wdata_b,
    input  rdata_a, ack_a, rdata_b, ack_b, wait_n
  );

  modport slave (
    input  rd_a, wr_a, addr_a, wdata_a, rd_b, wr_b, addr_b, wdata_b,
    output rdata_a, ack_a, rdata_b, ack_b, wait_n
  );
endinterface

// File: rtl/fisc_mem_responder.sv
// Round-robin two-channel responder on one single-port array; ack pulses 2 cycles after capture.
// One access per 3 cycles; a queued channel sees wait_n=0 while the other channel is served.
module fisc_mem_responder #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input logic       clk,
  input logic       reset_n,
  fisc_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  state_t            state, state_nxt;
  logic              sel, sel_nxt;   // 0 = channel a, 1 = channel b
  logic              rr_last;
  logic              pend_a, pend_b, pend_a_nxt, pend_b_nxt;
  logic              op_wr_a, op_wr_b;
  logic [ADDR_W-1:0] addr_la, addr_lb;
  logic [DATA_W-1:0] wdata_la, wdata_lb;
  logic              ack_a, ack_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              wait_n, wait_nxt;
  logic              cap_a, cap_b;
  logic              srv_wr;
  logic [ADDR_W-1:0] srv_addr;
  logic [DATA_W-1:0] srv_wdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // The registered ack blocks re-capture in the ack cycle of a held strobe.
  assign cap_a = (bus.rd_a | bus.wr_a) & ~pend_a & ~ack_a;
  assign cap_b = (bus.rd_b | bus.wr_b) & ~pend_b & ~ack_b;

  assign srv_wr    = sel ? op_wr_b  : op_wr_a;
  assign srv_addr  = sel ? addr_lb  : addr_la;
  assign srv_wdata = sel ? wdata_lb : wdata_la;

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    pend_a_nxt = cap_a | (pend_a & ~(state == SERVE && !sel));
    pend_b_nxt = cap_b | (pend_b & ~(state == SERVE && sel));
    wait_nxt   = 1'b1;
    case (state)
      IDLE: begin
        if (pend_a && (!pend_b || rr_last)) begin
          sel_nxt   = 1'b0;
          state_nxt = SERVE;
        end else if (pend_b) begin
          sel_nxt   = 1'b1;
          state_nxt = SERVE;
        end
      end
      SERVE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != IDLE && ((pend_a_nxt && sel_nxt) || (pend_b_nxt && !sel_nxt)))
      wait_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      rr_last  <= 1'b1;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      op_wr_a  <= 1'b0;
      op_wr_b  <= 1'b0;
      addr_la  <= '0;
      addr_lb  <= '0;
      wdata_la <= '0;
      wdata_lb <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      wait_n   <= 1'b1;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      pend_a <= pend_a_nxt;
      pend_b <= pend_b_nxt;
      wait_n <= wait_nxt;
      ack_a  <= (state == SERVE) && !sel;
      ack_b  <= (state == SERVE) && sel;
      if (cap_a) begin
        op_wr_a  <= bus.wr_a;
        addr_la  <= bus.addr_a;
        wdata_la <= bus.wdata_a;
      end
      if (cap_b) begin
        op_wr_b  <= bus.wr_b;
        addr_lb  <= bus.addr_b;
        wdata_lb <= bus.wdata_b;
      end
      if (state == SERVE) begin
        rr_last <= sel;
        if (!srv_wr) begin
          if (sel) rdata_b <= mem[srv_addr];
          else     rdata_a <= mem[srv_addr];
        end
      end
    end
  end

  // Array is never reset; a reset landing on the SERVE edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset_n && state == SERVE && srv_wr)
      mem[srv_addr] <= srv_wdata;
  end

  assign bus.ack_a   = ack_a;
  assign bus.ack_b   = ack_b;
  assign bus.rdata_a = rdata_a;
  assign bus.rdata_b = rdata_b;
  assign bus.wait_n  = wait_n;

endmodule

// File: tb/tb_fisc_mem_responder.sv
// Directed bench for fisc_mem_responder: latency, round-robin, held strobes, wr-priority, reset abort.
module tb_fisc_mem_responder;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  fisc_mem_if #(.DATA_W(64), .ADDR_W(10)) bus ();

  fisc_mem_responder #(.DATA_W(64), .ADDR_W(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single access on one channel; lat is edges from capture to ack, -1 on timeout.
  task automatic do_acc(input bit ch, input bit rd, input bit wr, input logic [9:0] a,
                        input logic [63:0] d, output int lat, output logic [63:0] rv);
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    if (ch) begin bus.rd_b = rd; bus.wr_b = wr; bus.addr_b = a; bus.wdata_b = d; end
    else    begin bus.rd_a = rd; bus.wr_a = wr; bus.addr_a = a; bus.wdata_a = d; end
    while (n < 20 && !got) begin
      step();
      n++;
      if (ch ? bus.ack_b : bus.ack_a) got = 1;
    end
    lat = got ? n - 1 : -1;
    rv  = ch ? bus.rdata_b : bus.rdata_a;
    if (ch) begin bus.rd_b = 0; bus.wr_b = 0; end
    else    begin bus.rd_a = 0; bus.wr_a = 0; end
    step();
  endtask

  // Simultaneous reads on both channels; records the edge index of each ack.
  task automatic both_rd(input logic [9:0] aa, input logic [9:0] ab, output int ca, output int cb,
                         output logic [63:0] va, output logic [63:0] vb, output int overlap);
    int n;
    n = 0; ca = -1; cb = -1; overlap = 0; va = '0; vb = '0;
    bus.rd_a = 1; bus.addr_a = aa;
    bus.rd_b = 1; bus.addr_b = ab;
    while (n < 30 && (ca < 0 || cb < 0)) begin
      step();
      n++;
      if (bus.ack_a && bus.ack_b) overlap++;
      if (bus.ack_a && ca < 0) begin ca = n; va = bus.rdata_a; bus.rd_a = 0; end
      if (bus.ack_b && cb < 0) begin cb = n; vb = bus.rdata_b; bus.rd_b = 0; end
    end
    bus.rd_a = 0; bus.rd_b = 0;
    step();
  endtask

  initial begin
    int          lat, ca, cb, ov, k, extra;
    int          rec [3];
    logic [63:0] rv, va, vb;
    n_tests = 0;
    n_fail  = 0;
    bus.rd_a = 0; bus.wr_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.rd_b = 0; bus.wr_b = 0; bus.addr_b = '0; bus.wdata_b = '0;
    reset_n = 0;
    step(); step();
    check("rst_ack_a", bus.ack_a, 0);
    check("rst_ack_b", bus.ack_b, 0);
    check("rst_rdata_a", bus.rdata_a, 0);
    check("rst_rdata_b", bus.rdata_b, 0);
    check("rst_wait_n", bus.wait_n, 1);
    reset_n = 1;
    step();

    // Write then read back on channel a.
    do_acc(0, 0, 1, 10'd5, 64'hDEAD_BEEF_0123_4567, lat, rv);
    check("t1_wr_lat", lat, 2);
    check("t1_wr_rdata_a", rv, 0);
    do_acc(0, 1, 0, 10'd5, 64'h0, lat, rv);
    check("t1_rd_lat", lat, 2);
    check("t1_rd_data", rv, 64'hDEAD_BEEF_0123_4567);

    // Contention after a B access: A wins, B follows 3 cycles later.
    do_acc(0, 0, 1, 10'd3, 64'd11, lat, rv);
    do_acc(1, 0, 1, 10'd7, 64'd22, lat, rv);
    check("t2_pre_lat_b", lat, 2);
    bus.rd_a = 1; bus.addr_a = 10'd3;
    bus.rd_b = 1; bus.addr_b = 10'd7;
    step();
    check("t2_e0_ack_a", bus.ack_a, 0);
    check("t2_e0_wait_n", bus.wait_n, 1);
    step();
    check("t2_e1_wait_n", bus.wait_n, 0);
    step();
    check("t2_e2_ack_a", bus.ack_a, 1);
    check("t2_e2_ack_b", bus.ack_b, 0);
    check("t2_e2_rdata_a", bus.rdata_a, 64'd11);
    check("t2_e2_wait_n", bus.wait_n, 0);
    bus.rd_a = 0;
    step();
    check("t2_e3_ack_a", bus.ack_a, 0);
    check("t2_e3_ack_b", bus.ack_b, 0);
    step();
    check("t2_e4_ack_b", bus.ack_b, 0);
    step();
    check("t2_e5_ack_b", bus.ack_b, 1);
    check("t2_e5_rdata_b", bus.rdata_b, 64'd22);
    bus.rd_b = 0;
    step();
    check("t2_e6_ack_b", bus.ack_b, 0);
    check("t2_e6_wait_n", bus.wait_n, 1);

    // Contention after an A access: round-robin now favours B.
    do_acc(0, 1, 0, 10'd3, 64'h0, lat, rv);
    check("t3_solo_a", rv, 64'd11);
    both_rd(10'd3, 10'd7, ca, cb, va, vb, ov);
    check("t3_ack_b_cycle", cb, 3);
    check("t3_ack_a_cycle", ca, 6);
    check("t3_rdata_a", va, 64'd11);
    check("t3_rdata_b", vb, 64'd22);
    check("t3_no_overlap", ov, 0);

    // Held rd_a across three accesses: one ack per 4-cycle window.
    do_acc(0, 0, 1, 10'd20, 64'h100, lat, rv);
    do_acc(0, 0, 1, 10'd21, 64'h101, lat, rv);
    do_acc(0, 0, 1, 10'd22, 64'h102, lat, rv);
    bus.rd_a = 1; bus.addr_a = 10'd20;
    k = 0;
    for (int n = 1; n <= 40 && k < 3; n++) begin
      step();
      if (bus.ack_a) begin
        rec[k] = n;
        check("t4_rdata", bus.rdata_a, 64'h100 + 64'(k));
        k++;
        if (k < 3) bus.addr_a = 10'(20 + k);
        else       bus.rd_a = 0;
      end
    end
    bus.rd_a = 0;
    check("t4_ack_count", k, 3);
    extra = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (bus.ack_a) extra++;
    end
    check("t4_extra_ack", extra, 0);
    if (k == 3) begin
      check("t4_first", rec[0], 3);
      check("t4_gap1", rec[1] - rec[0], 4);
      check("t4_gap2", rec[2] - rec[1], 4);
    end

    // rd and wr together at the top address: write wins; rdata_b untouched.
    do_acc(1, 1, 1, 10'd1023, 64'h1, lat, rv);
    check("t5_wr_lat", lat, 2);
    check("t5_rdata_b_kept", rv, 64'd22);
    do_acc(1, 1, 0, 10'd1023, 64'h0, lat, rv);
    check("t5_rd_1023", rv, 64'h1);

    // Reset during SERVE aborts the write.
    do_acc(0, 0, 1, 10'd9, 64'hAA, lat, rv);
    bus.wr_a = 1; bus.addr_a = 10'd9; bus.wdata_a = 64'hFF;
    step();
    step();
    reset_n = 0;
    bus.wr_a = 0;
    step();
    check("t6_ack_a", bus.ack_a, 0);
    check("t6_rdata_a", bus.rdata_a, 0);
    check("t6_rdata_b", bus.rdata_b, 0);
    check("t6_wait_n", bus.wait_n, 1);
    reset_n = 1;
    step();
    check("t6_ack_a_after", bus.ack_a, 0);
    do_acc(0, 1, 0, 10'd9, 64'h0, lat, rv);
    check("t6_rd_lat", lat, 2);
    check("t6_rd_9", rv, 64'hAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
